// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the I/D memory port arbiter.
// Widths, FSM state encoding, requester ids, op encoding and the latched request payload.
package mem_arb_pkg;

   localparam int unsigned ADDR_W = 28;
   localparam int unsigned DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   // A requester raising read and write together is served as a write.
   function automatic op_e decode_op(input logic wr);
      return wr ? OP_WR : OP_RD;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Block-port handshake bundle, used for both requester sides and the memory side.
interface mem_port_arbiter_if;
   import mem_arb_pkg::*;

   logic              read;
   logic              write;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic [DATA_W-1:0] rdata;

   modport master (output read, output write, output addr, output wdata,
                   input  ready, input  rdata);
   modport slave  (input  read, input  write, input  addr, input  wdata,
                   output ready, output rdata);
endinterface

// File: rtl/arb_pick.sv
// Combinational winner select between the I-side and D-side requesters.
// ARB_ROUND_ROBIN_EN: simultaneous requests go to the side that was not granted last.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic    i_req,
   input  logic    d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  req_id_e last_grant,
`endif
   output req_id_e grant_c
);

   always_comb begin
      grant_c = REQ_I;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         if (last_grant == REQ_I) grant_c = REQ_D;
         else                     grant_c = REQ_I;
`else
         grant_c = REQ_D;
`endif
      end else if (d_req) begin
         grant_c = REQ_D;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I-side and D-side block requests onto one slow memory port.
// Optional ARB_ROUND_ROBIN_EN switches fixed D-over-I priority to alternating grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input logic                clk,
   input logic                rst_n,
   mem_port_arbiter_if.slave  i_port,
   mem_port_arbiter_if.slave  d_port,
   mem_port_arbiter_if.master mem
);

   state_e            state;
   req_id_e           grant_q;
   req_id_e           pick_c;
   mem_req_t          req_q;
   mem_req_t          sel_c;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              i_ready_q;
   logic              d_ready_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_req_c;
   logic              d_req_c;
`ifdef ARB_ROUND_ROBIN_EN
   req_id_e           last_grant_q;
`endif

   assign i_req_c = i_port.read | i_port.write;
   assign d_req_c = d_port.read | d_port.write;

   arb_pick u_arb_pick (
      .i_req      (i_req_c),
      .d_req      (d_req_c),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant (last_grant_q),
`endif
      .grant_c    (pick_c)
   );

   // Payload of whichever side the arbiter picks this cycle.
   always_comb begin
      sel_c = '{op: decode_op(i_port.write), addr: i_port.addr, wdata: i_port.wdata};
      if (pick_c == REQ_D) begin
         sel_c = '{op: decode_op(d_port.write), addr: d_port.addr, wdata: d_port.wdata};
      end
   end

   // IDLE -> BUSY -> RESP -> IDLE; IDLE always lasts at least one cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         grant_q     <= REQ_I;
         req_q       <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
         last_grant_q <= REQ_I;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req_c || d_req_c) begin
                  grant_q     <= pick_c;
                  req_q       <= sel_c;
                  mem_read_q  <= (sel_c.op == OP_RD);
                  mem_write_q <= (sel_c.op == OP_WR);
`ifdef ARB_ROUND_ROBIN_EN
                  last_grant_q <= pick_c;
`endif
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (mem.ready) begin
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  if (req_q.op == OP_RD) begin
                     if (grant_q == REQ_D) d_rdata_q <= mem.rdata;
                     else                  i_rdata_q <= mem.rdata;
                  end
                  i_ready_q <= (grant_q == REQ_I);
                  d_ready_q <= (grant_q == REQ_D);
                  state     <= RESP;
               end
            end
            RESP: begin
               i_ready_q <= 1'b0;
               d_ready_q <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem.read     = mem_read_q;
   assign mem.write    = mem_write_q;
   assign mem.addr     = req_q.addr;
   assign mem.wdata    = req_q.wdata;
   assign i_port.ready = i_ready_q;
   assign i_port.rdata = i_rdata_q;
   assign d_port.ready = d_ready_q;
   assign d_port.rdata = d_rdata_q;

endmodule
